// File: rtl/stage_writeback.sv
// Writeback stage of a small byte-code machine. Retires one operation per
// cycle: DRAM writes for INC/DEC, console output for OUT (stalling while the
// console is busy), and loop resolution against a LIFO of loop start
// addresses. Loop resolutions are registered and presented for exactly one
// cycle after the loop op is accepted.
module stage_writeback #(
   parameter int A_WIDTH    = 12,
   parameter int D_WIDTH    = 8,
   parameter int C_WIDTH    = 12,
   parameter int SP_WIDTH   = 4,
   parameter int OPCODE_MSB = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [OPCODE_MSB:0]   operation,
   input  logic [D_WIDTH-1:0]    a,
   input  logic [C_WIDTH-1:0]    pc,
   output logic                  ack,
   input  logic [A_WIDTH-1:0]    dp,
   output logic                  dwe,
   output logic [A_WIDTH-1:0]    dwa,
   output logic [D_WIDTH-1:0]    dwd,
   output logic [7:0]            cq,
   output logic                  cwr,
   input  logic                  cbsy,
   output logic                  lresolve,
   output logic                  lskip,
   output logic                  lbranch,
   output logic [C_WIDTH-1:0]    ltarget,
   output logic                  overflow,
   output logic                  underflow
);

   // One-hot operation bit positions.
   localparam int OP_INC       = 0;
   localparam int OP_DEC       = 1;
   localparam int OP_INCDP     = 2;
   localparam int OP_DECDP     = 3;
   localparam int OP_OUT       = 4;
   localparam int OP_IN        = 5;
   localparam int OP_LOOPBEGIN = 6;
   localparam int OP_LOOPEND   = 7;

   localparam int DEPTH = 2 ** SP_WIDTH;

   typedef enum logic {
      RUN,
      RESOLVE
   } state_t;

   state_t                 state;
   logic [SP_WIDTH:0]      sp;
   logic [C_WIDTH-1:0]     stack [DEPTH];

   logic                   lresolve_q;
   logic                   lskip_q;
   logic                   lbranch_q;
   logic [C_WIDTH-1:0]     ltarget_q;
   logic                   overflow_q;
   logic                   underflow_q;

   logic                   is_inc;
   logic                   is_dec;
   logic                   is_out;
   logic                   is_lbegin;
   logic                   is_lend;
   logic                   bubble;
   logic                   a_zero;
   logic                   stack_full;
   logic                   stack_empty;
   logic [SP_WIDTH:0]      sp_dec;
   logic [C_WIDTH-1:0]     top;
   logic                   ack_raw;
   logic                   loop_accept;

   assign is_inc      = operation[OP_INC];
   assign is_dec      = operation[OP_DEC];
   assign is_out      = operation[OP_OUT];
   assign is_lbegin   = operation[OP_LOOPBEGIN];
   assign is_lend     = operation[OP_LOOPEND];
   assign bubble      = (operation == '0);
   assign a_zero      = (a == '0);
   assign stack_full  = (sp == (SP_WIDTH + 1)'(DEPTH));
   assign stack_empty = (sp == '0);
   assign sp_dec      = sp - 1'b1;
   assign top         = stack[sp_dec[SP_WIDTH-1:0]];

   // Acceptance: console back-pressure stalls OUT; while a loop resolution is
   // pending only bubbles are retired. Nothing is accepted during reset.
   always_comb begin
      ack_raw = 1'b0;
      if (state == RESOLVE) begin
         ack_raw = bubble;
      end else begin
         ack_raw = !(is_out && cbsy);
      end
   end

   assign ack         = reset && ack_raw;
   assign loop_accept = ack && (state == RUN) && (is_lbegin || is_lend);

   assign dwe = ack && (is_inc || is_dec);
   assign dwa = dp;
   assign dwd = a;
   assign cwr = ack && is_out;
   assign cq  = a[7:0];

   // Registered loop outputs are masked while reset is held so a resolution
   // registered just before reset never reaches fetch.
   assign lresolve  = reset && lresolve_q;
   assign lskip     = reset && lskip_q;
   assign lbranch   = reset && lbranch_q;
   assign ltarget   = reset ? ltarget_q : '0;
   assign overflow  = reset && overflow_q;
   assign underflow = reset && underflow_q;

   // Loop start address storage; written on a non-dropped push only.
   always_ff @(posedge clk) begin
      if (loop_accept && is_lbegin && !a_zero && !stack_full) begin
         stack[sp[SP_WIDTH-1:0]] <= pc;
      end
   end

   // Resolution FSM: stack pointer, one-cycle resolution pulse, sticky flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         sp          <= '0;
         lresolve_q  <= 1'b0;
         lskip_q     <= 1'b0;
         lbranch_q   <= 1'b0;
         ltarget_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         lresolve_q <= 1'b0;
         lskip_q    <= 1'b0;
         lbranch_q  <= 1'b0;
         ltarget_q  <= '0;
         case (state)
            RUN: begin
               if (loop_accept) begin
                  state      <= RESOLVE;
                  lresolve_q <= 1'b1;
                  if (is_lbegin) begin
                     if (a_zero) begin
                        lskip_q <= 1'b1;
                     end else if (stack_full) begin
                        overflow_q <= 1'b1;
                     end else begin
                        sp <= sp + 1'b1;
                     end
                  end else begin
                     if (stack_empty) begin
                        underflow_q <= 1'b1;
                     end else if (!a_zero) begin
                        lbranch_q <= 1'b1;
                        ltarget_q <= top + 1'b1;
                     end else begin
                        sp <= sp_dec;
                     end
                  end
               end
            end
            RESOLVE: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_writeback.sv
// Self-checking bench for stage_writeback: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_stage_writeback;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int CW = 12;
   localparam int SPW = 4;
   localparam int DEPTH = 16;

   localparam int OP_INC = 0;
   localparam int OP_DEC = 1;
   localparam int OP_INCDP = 2;
   localparam int OP_DECDP = 3;
   localparam int OP_OUT = 4;
   localparam int OP_IN = 5;
   localparam int OP_LB = 6;
   localparam int OP_LE = 7;
   localparam int BUB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [7:0]    operation;
   logic [DW-1:0] a;
   logic [CW-1:0] pc;
   logic          ack;
   logic [AW-1:0] dp;
   logic          dwe;
   logic [AW-1:0] dwa;
   logic [DW-1:0] dwd;
   logic [7:0]    cq;
   logic          cwr;
   logic          cbsy;
   logic          lresolve;
   logic          lskip;
   logic          lbranch;
   logic [CW-1:0] ltarget;
   logic          overflow;
   logic          underflow;

   stage_writeback #(
      .A_WIDTH(AW), .D_WIDTH(DW), .C_WIDTH(CW), .SP_WIDTH(SPW), .OPCODE_MSB(7)
   ) dut (
      .clk(clk), .reset(reset), .operation(operation), .a(a), .pc(pc),
      .ack(ack), .dp(dp), .dwe(dwe), .dwa(dwa), .dwd(dwd), .cq(cq),
      .cwr(cwr), .cbsy(cbsy), .lresolve(lresolve), .lskip(lskip),
      .lbranch(lbranch), .ltarget(ltarget), .overflow(overflow),
      .underflow(underflow)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: loop stack as a queue, pending resolution, flags.
   int stk[$];
   bit m_pending, m_lres, m_lskip, m_lbr, m_ovf, m_unf;
   int m_lt;
   // Current inputs and expectations for the cycle being applied.
   int cur_op, cur_a, cur_pc;
   bit cur_rst;
   bit e_ack, e_dwe, e_cwr, x_lres, x_lskip, x_lbr, x_ovf, x_unf;
   int x_lt;

   task automatic apply(input int opi, input int av, input int pcv, input int dpv,
                        input bit busy, input bit rstv);
      @(negedge clk);
      operation = (opi < 8) ? 8'(1 << opi) : 8'h00;
      a = DW'(av);
      pc = CW'(pcv);
      dp = AW'(dpv);
      cbsy = busy;
      reset = rstv;
      cur_op = opi; cur_a = av; cur_pc = pcv; cur_rst = rstv;
      if (!rstv) e_ack = 1'b0;
      else if (m_pending) e_ack = (opi == BUB);
      else e_ack = !(opi == OP_OUT && busy);
      e_dwe = e_ack && (opi == OP_INC || opi == OP_DEC);
      e_cwr = e_ack && (opi == OP_OUT);
      x_lres = rstv && m_lres;
      x_lskip = rstv && m_lskip;
      x_lbr = rstv && m_lbr;
      x_lt = rstv ? m_lt : 0;
      x_ovf = rstv && m_ovf;
      x_unf = rstv && m_unf;
      #1;
   endtask

   task automatic tick();
      if (!cur_rst) begin
         stk.delete();
         m_pending = 0; m_lres = 0; m_lskip = 0; m_lbr = 0; m_lt = 0;
         m_ovf = 0; m_unf = 0;
      end else begin
         m_pending = 0; m_lres = 0; m_lskip = 0; m_lbr = 0; m_lt = 0;
         if (e_ack && cur_op == OP_LB) begin
            m_pending = 1; m_lres = 1;
            if (cur_a == 0) m_lskip = 1;
            else if (stk.size() == DEPTH) m_ovf = 1;
            else stk.push_back(cur_pc);
         end else if (e_ack && cur_op == OP_LE) begin
            m_pending = 1; m_lres = 1;
            if (stk.size() == 0) m_unf = 1;
            else if (cur_a != 0) begin
               m_lbr = 1;
               m_lt = (stk[$] + 1) % (1 << CW);
            end else void'(stk.pop_back());
         end
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      apply(OP_INC, 8'h11, 0, 3, 0, 0);
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack); end
      vectors++; if (dwe !== 1'b0) begin miscompares++; $display("FAIL reset_dwe got %b want 0", dwe); end
      tick();
      apply(OP_OUT, 8'h22, 0, 0, 0, 0);
      vectors++; if (cwr !== 1'b0) begin miscompares++; $display("FAIL reset_cwr got %b want 0", cwr); end
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if ({lresolve, lskip, lbranch, overflow, underflow} !== 5'b0) begin
         miscompares++; $display("FAIL reset_flags got %b want 00000", {lresolve, lskip, lbranch, overflow, underflow}); end
      vectors++; if (ltarget !== '0) begin miscompares++; $display("FAIL reset_ltarget got %h want 000", ltarget); end
      vectors++; if (dut.sp !== '0) begin miscompares++; $display("FAIL reset_sp got %0d want 0", dut.sp); end
      tick();
   endtask

   task automatic test_dram_write();
      apply(OP_INC, 8'h2A, 0, 12'h005, 0, 1);
      vectors++; if ({ack, dwe, dwa, dwd} !== {1'b1, 1'b1, 12'h005, 8'h2A}) begin
         miscompares++; $display("FAIL inc_write got ack=%b dwe=%b dwa=%h dwd=%h want 1 1 005 2a", ack, dwe, dwa, dwd); end
      tick();
      apply(OP_DEC, 8'hFF, 0, 12'hABC, 0, 1);
      vectors++; if ({dwe, dwa, dwd} !== {1'b1, 12'hABC, 8'hFF}) begin
         miscompares++; $display("FAIL dec_write got dwe=%b dwa=%h dwd=%h want 1 abc ff", dwe, dwa, dwd); end
      tick();
      apply(OP_INCDP, 8'h01, 0, 12'h010, 1, 1);
      vectors++; if ({ack, dwe, cwr} !== 3'b100) begin
         miscompares++; $display("FAIL incdp_noeffect got ack/dwe/cwr=%b want 100", {ack, dwe, cwr}); end
      tick();
   endtask

   task automatic test_out_stall();
      for (int i = 0; i < 3; i++) begin
         apply(OP_OUT, 8'h41, 0, 0, 1, 1);
         vectors++; if ({ack, cwr} !== 2'b00) begin
            miscompares++; $display("FAIL out_stall%0d got ack/cwr=%b want 00", i, {ack, cwr}); end
         tick();
      end
      apply(OP_OUT, 8'h41, 0, 0, 0, 1);
      vectors++; if ({ack, cwr, cq} !== {1'b1, 1'b1, 8'h41}) begin
         miscompares++; $display("FAIL out_release got ack=%b cwr=%b cq=%h want 1 1 41", ack, cwr, cq); end
      tick();
   endtask

   task automatic test_loop_branch();
      apply(OP_LB, 3, 12'h010, 0, 0, 1);
      tick();
      apply(OP_LE, 2, 12'h014, 0, 0, 1);   // held off while resolution pending
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL resolve_hold got ack=%b want 0", ack); end
      vectors++; if ({lresolve, lskip, lbranch} !== 3'b100) begin
         miscompares++; $display("FAIL lb_continue got %b want 100", {lresolve, lskip, lbranch}); end
      tick();
      apply(OP_LE, 2, 12'h014, 0, 0, 1);
      vectors++; if (lresolve !== 1'b0) begin miscompares++; $display("FAIL lres_one_cycle got %b want 0", lresolve); end
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if ({lresolve, lbranch, ltarget} !== {1'b1, 1'b1, 12'h011}) begin
         miscompares++; $display("FAIL le_branch got lres=%b lbr=%b lt=%h want 1 1 011", lresolve, lbranch, ltarget); end
      tick();
      apply(OP_LE, 0, 12'h014, 0, 0, 1);
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if ({lresolve, lskip, lbranch} !== 3'b100) begin
         miscompares++; $display("FAIL le_exit got %b want 100", {lresolve, lskip, lbranch}); end
      vectors++; if (dut.sp !== '0) begin miscompares++; $display("FAIL le_pop_sp got %0d want 0", dut.sp); end
      tick();
   endtask

   task automatic test_loop_skip();
      apply(OP_LB, 0, 12'h020, 0, 0, 1);
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if ({lresolve, lskip, lbranch} !== 3'b110) begin
         miscompares++; $display("FAIL lb_skip got %b want 110", {lresolve, lskip, lbranch}); end
      vectors++; if (dut.sp !== '0) begin miscompares++; $display("FAIL lb_skip_sp got %0d want 0", dut.sp); end
      tick();
   endtask

   task automatic test_overflow_underflow();
      apply(BUB, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 17; i++) begin
         apply(OP_LB, 1, 12'h100 + i, 0, 0, 1);
         tick();
         apply(BUB, 0, 0, 0, 0, 1);
         vectors++; if (overflow !== (i == 16)) begin
            miscompares++; $display("FAIL overflow_push%0d got %b want %b", i, overflow, (i == 16)); end
         tick();
      end
      vectors++; if (dut.sp !== 5'd16) begin miscompares++; $display("FAIL overflow_sp got %0d want 16", dut.sp); end
      apply(BUB, 0, 0, 0, 0, 0);
      tick();
      apply(OP_LE, 5, 12'h200, 0, 0, 1);
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if ({lresolve, lbranch, underflow, overflow} !== 4'b1010) begin
         miscompares++; $display("FAIL underflow got lres/lbr/unf/ovf=%b want 1010", {lresolve, lbranch, underflow, overflow}); end
      vectors++; if (dut.sp !== '0) begin miscompares++; $display("FAIL underflow_sp got %0d want 0", dut.sp); end
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %b want 1", underflow); end
      tick();
   endtask

   task automatic test_reset_during_resolve();
      apply(BUB, 0, 0, 0, 0, 0);
      tick();
      apply(OP_LB, 1, 12'h030, 0, 0, 1);
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      tick();
      apply(OP_LE, 1, 12'h038, 0, 0, 1);
      tick();
      apply(BUB, 0, 0, 0, 0, 0);
      vectors++; if ({lresolve, lskip, lbranch, overflow, underflow, ack} !== 6'b0) begin
         miscompares++; $display("FAIL rst_resolve got %b want 000000", {lresolve, lskip, lbranch, overflow, underflow, ack}); end
      vectors++; if (ltarget !== '0) begin miscompares++; $display("FAIL rst_resolve_lt got %h want 000", ltarget); end
      tick();
      apply(BUB, 0, 0, 0, 0, 1);
      vectors++; if ({lresolve, lbranch} !== 2'b00) begin
         miscompares++; $display("FAIL rst_after got %b want 00", {lresolve, lbranch}); end
      vectors++; if (dut.sp !== '0) begin miscompares++; $display("FAIL rst_after_sp got %0d want 0", dut.sp); end
      tick();
   endtask

   task automatic test_random();
      int op, av, pcv, r;
      bit rstv, held;
      op = BUB; av = 0; pcv = 0; held = 0;
      for (int n = 0; n < 800; n++) begin
         if (!held) begin
            r = $urandom_range(0, 13);
            op = (r < 8) ? r : (r < 10) ? OP_LB : (r < 12) ? OP_LE : BUB;
            av = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
            pcv = $urandom_range(0, 4095);
         end
         rstv = ($urandom_range(0, 99) != 0);
         apply(op, av, pcv, $urandom_range(0, 4095), ($urandom_range(0, 4) < 2), rstv);
         vectors++; if ({ack, dwe, cwr} !== {e_ack, e_dwe, e_cwr}) begin
            miscompares++; $display("FAIL rnd_ctrl n=%0d got ack/dwe/cwr=%b want %b", n, {ack, dwe, cwr}, {e_ack, e_dwe, e_cwr}); end
         if (e_dwe) begin
            vectors++; if ({dwa, dwd} !== {dp, a}) begin
               miscompares++; $display("FAIL rnd_dram n=%0d got %h/%h want %h/%h", n, dwa, dwd, dp, a); end
         end
         if (e_cwr) begin
            vectors++; if (cq !== 8'(cur_a)) begin
               miscompares++; $display("FAIL rnd_cq n=%0d got %h want %h", n, cq, 8'(cur_a)); end
         end
         vectors++; if ({lresolve, lskip, lbranch, overflow, underflow} !== {x_lres, x_lskip, x_lbr, x_ovf, x_unf}) begin
            miscompares++; $display("FAIL rnd_loop n=%0d got %b want %b", n, {lresolve, lskip, lbranch, overflow, underflow},
                                    {x_lres, x_lskip, x_lbr, x_ovf, x_unf}); end
         vectors++; if (ltarget !== CW'(x_lt)) begin
            miscompares++; $display("FAIL rnd_ltarget n=%0d got %h want %h", n, ltarget, CW'(x_lt)); end
         held = rstv && !e_ack;
         tick();
         if (rstv) begin
            vectors++; #1; if (dut.sp !== 5'(stk.size())) begin
               miscompares++; $display("FAIL rnd_sp n=%0d got %0d want %0d", n, dut.sp, stk.size()); end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; operation = '0; a = '0; pc = '0; dp = '0; cbsy = 1'b0;
      cur_rst = 1'b0;
      tick();
      test_reset();
      test_dram_write();
      test_out_stall();
      test_loop_branch();
      test_loop_skip();
      test_overflow_underflow();
      test_reset_during_resolve();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
